// File: rtl/mem_arb_pkg.sv
// Shared encodings for the instruction/data RAM port arbiter: data-port opcodes,
// arbiter FSM states and grant sources.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    OP_NONE  = 2'd0,
    OP_STORE = 2'd1,
    OP_LOAD  = 2'd2,
    OP_RSVD  = 2'd3
  } mem_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_e;

  typedef enum logic {
    GRANT_FETCH = 1'b0,
    GRANT_DATA  = 1'b1
  } grant_e;

  // Wide enough for RAM_LAT-1 over the supported latency range 1..7.
  localparam int LAT_CNT_W = 3;

endpackage

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between the CPU fetch port and data port, one access
// in flight, with latched operands and a single ack pulse per access.
//
// state | meaning
// IDLE  | arbitrate fetch vs data, latch operands of the winner
// ISSUE | drive RAM_EN (and RAM_WE for stores) for one cycle
// WAIT  | count down remaining RAM read latency
// RESP  | capture read data / finish store, then back to IDLE
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int AW      = 16,
  parameter int RAM_LAT = 1
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          FETCH_REQ,
  input  logic [31:0]   ADDR,
  output logic [31:0]   MEM_INST,
  output logic          MEM_INST_ENB,
  input  logic [1:0]    MEM_OP,
  input  logic [15:0]   MEM_ADDR,
  input  logic [31:0]   MEM_STORE,
  output logic [31:0]   MEM_LOAD,
  output logic          READ_READY,
  output logic          MEM_WRITEENABLE,
  output logic          STORE_DONE,
  output logic          RAM_EN,
  output logic          RAM_WE,
  output logic [AW-1:0] RAM_ADDR,
  output logic [31:0]   RAM_WDATA,
  input  logic [31:0]   RAM_RDATA
);

  localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(RAM_LAT - 1);

  arb_state_e           state_q, state_d;
  grant_e               last_grant_q, src_q;
  logic                 is_store_q;
  logic [AW-1:0]        addr_q;
  logic [31:0]          wdata_q;
  logic [LAT_CNT_W-1:0] cnt_q;

  logic        data_req, ack_busy, grant_data, grant_fetch;
  logic [31:0] mem_addr_ext;
  logic        unused_bits;

  assign mem_addr_ext = {16'b0, MEM_ADDR};
  assign unused_bits  = ^{ADDR, mem_addr_ext};
  assign data_req     = (MEM_OP == OP_STORE) || (MEM_OP == OP_LOAD);
  // A read ack is pulsed while already back in IDLE; the acked requester is still
  // high that cycle, so arbitration waits one cycle to avoid re-granting it.
  assign ack_busy     = MEM_INST_ENB | READ_READY;

  always_comb begin
    grant_data  = 1'b0;
    grant_fetch = 1'b0;
    if (state_q == ST_IDLE && !ack_busy) begin
      if (data_req && !(last_grant_q == GRANT_DATA && FETCH_REQ)) grant_data = 1'b1;
      else if (FETCH_REQ)                                         grant_fetch = 1'b1;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) state_q <= ST_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (grant_data || grant_fetch) state_d = ST_ISSUE;
      ST_ISSUE: state_d = (is_store_q || cnt_q == '0) ? ST_RESP : ST_WAIT;
      ST_WAIT:  if (cnt_q == '0) state_d = ST_RESP;
      ST_RESP:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    RAM_EN = (state_q == ST_ISSUE);
    RAM_WE = (state_q == ST_ISSUE) && is_store_q;
  end

  assign RAM_ADDR  = addr_q;
  assign RAM_WDATA = wdata_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      last_grant_q    <= GRANT_FETCH;
      src_q           <= GRANT_FETCH;
      is_store_q      <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      cnt_q           <= '0;
      MEM_INST        <= '0;
      MEM_LOAD        <= '0;
      MEM_INST_ENB    <= 1'b0;
      READ_READY      <= 1'b0;
      MEM_WRITEENABLE <= 1'b0;
      STORE_DONE      <= 1'b0;
    end else begin
      MEM_INST_ENB    <= 1'b0;
      READ_READY      <= 1'b0;
      MEM_WRITEENABLE <= 1'b0;
      STORE_DONE      <= 1'b0;

      if (grant_data) begin
        last_grant_q <= GRANT_DATA;
        src_q        <= GRANT_DATA;
        is_store_q   <= (MEM_OP == OP_STORE);
        addr_q       <= mem_addr_ext[AW-1:0];
        wdata_q      <= MEM_STORE;
        cnt_q        <= LAT_LOAD;
      end else if (grant_fetch) begin
        last_grant_q <= GRANT_FETCH;
        src_q        <= GRANT_FETCH;
        is_store_q   <= 1'b0;
        addr_q       <= ADDR[AW-1:0];
        cnt_q        <= LAT_LOAD;
      end

      if ((state_q == ST_ISSUE || state_q == ST_WAIT) && cnt_q != '0)
        cnt_q <= cnt_q - LAT_CNT_W'(1);

      // Store commits at the RAM on the ISSUE edge, so its ack lands in RESP.
      if (state_q == ST_ISSUE && is_store_q)
        STORE_DONE <= 1'b1;

      if (state_q == ST_RESP && !is_store_q) begin
        if (src_q == GRANT_FETCH) begin
          MEM_INST     <= RAM_RDATA;
          MEM_INST_ENB <= 1'b1;
        end else begin
          MEM_LOAD        <= RAM_RDATA;
          READ_READY      <= 1'b1;
          MEM_WRITEENABLE <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (RAM_LAT 1 and 3) with behavioural RAMs,
// directed scenarios plus randomized accesses checked against a word-level memory model.
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int K_FETCH = 1;
  localparam int K_LOAD  = 2;
  localparam int K_STORE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1;
  logic        sel = 1'b0;
  logic        fetch_req = 1'b0;
  logic [31:0] addr = '0;
  logic [1:0]  mem_op = OP_NONE;
  logic [15:0] mem_addr = '0;
  logic [31:0] mem_store = '0;

  logic [31:0] mem_inst, mem_load, ram_wdata;
  logic [15:0] ram_addr;
  logic        mem_inst_enb, read_ready, mem_we, store_done, ram_en, ram_we;

  int tests = 0, fails = 0;
  int en_cnt = 0, ack_cnt = 0, viol = 0;
  logic [31:0] ref_mem [2][64];

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int LAT = (g == 0) ? 1 : 3;
    logic        fr;
    logic [31:0] ad, ms, o_inst, o_load, r_wdata, r_rdata;
    logic [1:0]  op;
    logic [15:0] ma, r_addr;
    logic        o_ienb, o_rr, o_we, o_sd, r_en, r_we;
    logic [31:0] ram [0:65535];
    logic [31:0] pipe [0:LAT-1];

    assign fr = (sel == 1'(g)) ? fetch_req : 1'b0;
    assign ad = (sel == 1'(g)) ? addr      : 32'd0;
    assign op = (sel == 1'(g)) ? mem_op    : 2'd0;
    assign ma = (sel == 1'(g)) ? mem_addr  : 16'd0;
    assign ms = (sel == 1'(g)) ? mem_store : 32'd0;

    mem_port_arbiter #(.AW(16), .RAM_LAT(LAT)) dut (
      .CLK(clk), .RST(rst),
      .FETCH_REQ(fr), .ADDR(ad), .MEM_INST(o_inst), .MEM_INST_ENB(o_ienb),
      .MEM_OP(op), .MEM_ADDR(ma), .MEM_STORE(ms), .MEM_LOAD(o_load),
      .READ_READY(o_rr), .MEM_WRITEENABLE(o_we), .STORE_DONE(o_sd),
      .RAM_EN(r_en), .RAM_WE(r_we), .RAM_ADDR(r_addr), .RAM_WDATA(r_wdata),
      .RAM_RDATA(r_rdata)
    );

    always @(posedge clk) begin
      if (r_en && r_we) ram[r_addr] <= r_wdata;
      pipe[0] <= (r_en && !r_we) ? ram[r_addr] : 32'hDEAD_BEEF;
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
    assign r_rdata = pipe[LAT-1];
  end

  assign mem_inst     = sel ? inst[1].o_inst  : inst[0].o_inst;
  assign mem_load     = sel ? inst[1].o_load  : inst[0].o_load;
  assign mem_inst_enb = sel ? inst[1].o_ienb  : inst[0].o_ienb;
  assign read_ready   = sel ? inst[1].o_rr    : inst[0].o_rr;
  assign mem_we       = sel ? inst[1].o_we    : inst[0].o_we;
  assign store_done   = sel ? inst[1].o_sd    : inst[0].o_sd;
  assign ram_en       = sel ? inst[1].r_en    : inst[0].r_en;
  assign ram_we       = sel ? inst[1].r_we    : inst[0].r_we;
  assign ram_addr     = sel ? inst[1].r_addr  : inst[0].r_addr;
  assign ram_wdata    = sel ? inst[1].r_wdata : inst[0].r_wdata;

  // Protocol watcher: RAM strobes, ack overlap, write-enable pairing.
  always begin
    @(posedge clk);
    #2;
    if (ram_en) en_cnt++;
    ack_cnt += int'(mem_inst_enb) + int'(read_ready) + int'(store_done);
    if ((ram_we && !ram_en) || (mem_we != read_ready) ||
        (int'(mem_inst_enb) + int'(read_ready) + int'(store_done) > 1))
      viol++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int cur_lat();
    return sel ? 3 : 1;
  endfunction

  task automatic chk_zero(input string tag);
    chk({tag, "_inst"},  mem_inst,  32'd0);
    chk({tag, "_load"},  mem_load,  32'd0);
    chk({tag, "_wdata"}, ram_wdata, 32'd0);
    chk({tag, "_ctrl"},  {10'd0, ram_addr, mem_inst_enb, read_ready, mem_we, store_done, ram_en, ram_we}, 32'd0);
  endtask

  task automatic wait_ack(input int start, output int kind, output int cyc);
    kind = 0;
    cyc  = 0;
    for (int c = start; c <= 30; c++) begin
      @(negedge clk);
      if (mem_inst_enb)    kind = K_FETCH;
      else if (read_ready) kind = K_LOAD;
      else if (store_done) kind = K_STORE;
      if (kind != 0) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic access(input int kind, input logic [31:0] a, input logic [31:0] wd);
    int e0, got, cyc;
    logic [31:0] expd;
    e0   = en_cnt;
    expd = ref_mem[sel][a[5:0]];
    @(negedge clk);
    if (kind == K_FETCH) begin
      fetch_req = 1'b1;
      addr      = a;
    end else begin
      mem_op    = (kind == K_STORE) ? OP_STORE : OP_LOAD;
      mem_addr  = a[15:0];
      mem_store = wd;
    end
    @(negedge clk);
    chk("issue_en",   {31'd0, ram_en}, 32'd1);
    chk("issue_we",   {31'd0, ram_we}, {31'd0, kind == K_STORE});
    chk("issue_addr", {16'd0, ram_addr}, {16'd0, a[15:0]});
    if (kind == K_STORE) chk("issue_wdata", ram_wdata, wd);
    addr      = $urandom();
    mem_addr  = 16'($urandom());
    mem_store = $urandom();
    wait_ack(2, got, cyc);
    chk("ack_kind", got, kind);
    chk("ack_latency", cyc, (kind == K_STORE) ? 2 : cur_lat() + 2);
    if (kind == K_FETCH) chk("fetch_data", mem_inst, expd);
    if (kind == K_LOAD) begin
      chk("load_data", mem_load, expd);
      chk("load_wen", {31'd0, mem_we}, 32'd1);
    end
    if (kind == K_STORE) ref_mem[sel][a[5:0]] = wd;
    @(posedge clk);
    #1;
    fetch_req = 1'b0;
    mem_op    = OP_NONE;
    @(negedge clk);
    chk("one_ram_access", en_cnt - e0, 32'd1);
    if (kind == K_FETCH) chk("inst_held", mem_inst, expd);
    if (kind == K_LOAD)  chk("load_held", mem_load, expd);
  endtask

  initial begin
    int got, cyc, e0, a0, kind, idx;
    logic [31:0] a, wd;

    repeat (3) @(negedge clk);
    chk_zero("reset0");
    sel = 1'b1;
    #1;
    chk_zero("reset1");
    sel = 1'b0;
    rst = 1'b0;
    @(negedge clk);

    // Fetch and load on RAM_LAT=1
    access(K_STORE, 32'd4, 32'h0010_0093);
    access(K_FETCH, 32'd4, 32'd0);
    access(K_STORE, 32'd31, 32'h31);
    access(K_LOAD,  32'd31, 32'd0);

    // Load/store/readback on RAM_LAT=3
    sel = 1'b1;
    access(K_STORE, 32'd31, 32'h31);
    access(K_LOAD,  32'd31, 32'd0);
    access(K_STORE, 32'd31, 32'h32);
    access(K_LOAD,  32'd31, 32'd0);
    chk("readback_32", mem_load, 32'h32);

    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      for (int k = 0; k < 64; k++) access(K_STORE, 32'(k), $urandom());
    end

    for (int s = 0; s < 2; s++) begin
      sel = 1'(s);
      for (int n = 0; n < 60; n++) begin
        kind = int'($urandom_range(1, 3));
        idx  = int'($urandom_range(0, 63));
        wd   = $urandom();
        if (kind == K_FETCH) a = {16'($urandom()), 10'd0, 6'(idx)};
        else                 a = {26'd0, 6'(idx)};
        access(kind, a, wd);
      end
    end

    // Contention: after a fetch, data wins a simultaneous request
    sel = 1'b0;
    access(K_FETCH, 32'd2, 32'd0);
    @(negedge clk);
    fetch_req = 1'b1; addr = 32'd8;
    mem_op = OP_LOAD; mem_addr = 16'd9;
    wait_ack(1, got, cyc);
    chk("cont_a_first", got, K_LOAD);
    chk("cont_a_load", mem_load, ref_mem[0][9]);
    @(posedge clk); #1; mem_op = OP_NONE;
    wait_ack(1, got, cyc);
    chk("cont_a_second", got, K_FETCH);
    chk("cont_a_inst", mem_inst, ref_mem[0][8]);
    @(posedge clk); #1; fetch_req = 1'b0;
    @(negedge clk);

    // After a data grant, a waiting fetch goes first
    access(K_LOAD, 32'd10, 32'd0);
    @(negedge clk);
    fetch_req = 1'b1; addr = 32'd11;
    mem_op = OP_LOAD; mem_addr = 16'd12;
    wait_ack(1, got, cyc);
    chk("cont_b_first", got, K_FETCH);
    chk("cont_b_inst", mem_inst, ref_mem[0][11]);
    @(posedge clk); #1; fetch_req = 1'b0;
    wait_ack(1, got, cyc);
    chk("cont_b_second", got, K_LOAD);
    chk("cont_b_load", mem_load, ref_mem[0][12]);
    @(posedge clk); #1; mem_op = OP_NONE;
    @(negedge clk);

    // Reserved opcode is never granted
    e0 = en_cnt; a0 = ack_cnt;
    mem_op = OP_RSVD; mem_addr = 16'd3;
    repeat (10) @(negedge clk);
    chk("rsvd_no_ram", en_cnt - e0, 32'd0);
    chk("rsvd_no_ack", ack_cnt - a0, 32'd0);
    mem_op = OP_NONE;
    @(negedge clk);

    // Reset while a RAM_LAT=3 load sits in WAIT
    sel = 1'b1;
    @(negedge clk);
    mem_op = OP_LOAD; mem_addr = 16'd5;
    @(negedge clk);
    @(negedge clk);
    a0  = ack_cnt;
    rst = 1'b1;
    #1;
    chk_zero("rst_mid");
    mem_op = OP_NONE;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (8) @(negedge clk);
    chk("rst_no_ack", ack_cnt - a0, 32'd0);
    access(K_LOAD, 32'd5, 32'd0);

    chk("protocol_viol", viol, 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
